alu_sched: RTL
==============

# alu_sched

Two-requester scheduler that shares one registered ALU instance between two command sources. It arbitrates round-robin, issues one command at a time on the ALU control and operand pins, and waits the ALU's registered latency. It then returns the 6-bit result to the winning requester over a valid/ready response channel. It sits directly in front of the ALU; nothing else drives the ALU's inputs.

## Interface
- ALU_LAT, default 1: cycles from the ALU_en cycle until the ALU output C is stable; legal range 1–15.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  2  per-requester command valid (bit i = requester i)
- req_ready  out  2  per-requester accept; one-hot or zero
- req0_cmd, req1_cmd  in  17 each  command packed as {a_en, b_en, a_op[2:0], b_op[1:0], A[4:0], B[4:0]}
- alu_en  out  1  to ALU ALU_en
- alu_a_en, alu_b_en  out  1 each  to ALU a_en / b_en
- alu_a_op  out  3  to ALU a_op
- alu_b_op  out  2  to ALU b_op
- alu_a, alu_b  out  5 each  to ALU A / B (two's-complement)
- alu_c  in  6  from ALU C
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  1  requester index of the response
- rsp_data  out  6  ALU result
- rsp_err  out  1  command rejected (a_en=b_en=0)
- busy  out  1  high in every state except IDLE

## Operation
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is round-robin over req_valid. The requester not granted last wins a tie; a sole requester always wins.
  - req_ready[g] = 1 combinationally for the granted requester only. req_ready is 0 in all other states.
  - On req_valid[g] & req_ready[g], latch the command and g, and update the last-grant pointer to g.
- Next state from IDLE:
  - A latched command with a_en=b_en=0 goes straight to RESP with rsp_err=1 and rsp_data=0. It never touches the ALU.
  - Any other command goes to ISSUE.
- ISSUE lasts 1 cycle. alu_en=1 and the latched fields drive the ALU pins. Next state is WAIT.
- WAIT lasts ALU_LAT cycles, counted by a down-counter loaded with ALU_LAT-1.
  - alu_en=0; the operand and op pins hold the latched values.
  - On the final WAIT cycle, capture alu_c into rsp_data and go to RESP.
- RESP holds rsp_valid=1 and stable rsp_id, rsp_data and rsp_err until rsp_ready. On the handshake, go to IDLE.
- Operand/op pins hold their last issued values in IDLE. alu_en is high only in ISSUE, so exactly one pulse per accepted valid command.
- No arithmetic is performed here. rsp_data is the raw ALU C value.
- Requesters must hold req_valid and the command stable until accepted. A req_valid deasserted before acceptance is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0: alu_en, all alu_* pins, rsp_valid, rsp_id, rsp_data, rsp_err, busy and req_ready.
  - Last-grant pointer is 1, so requester 0 wins the first tie.
- Accept in cycle T. ISSUE occurs at T+1. WAIT covers T+2 .. T+1+ALU_LAT. rsp_valid first goes high at T+2+ALU_LAT. With ALU_LAT=1, rsp_valid rises at T+3.
- Rejected command: accept at T, rsp_valid at T+1, no alu_en pulse.
- Earliest next accept is the cycle after the rsp handshake. Minimum period is ALU_LAT+3 cycles per command.
- rsp_ready held high already in the first RESP cycle completes the response in that cycle.
- Reset mid-operation: asynchronous return to reset values; any in-flight command and pending response are dropped. The ALU is not re-pulsed.
- Both requesters valid continuously: grants strictly alternate.

## Test plan
- Add, ALU_LAT=1: req0 sends a_en=1, b_en=0, a_op=0, A=5, B=3, rsp_ready=1.
  - Expect a single alu_en pulse at T+1.
  - Expect rsp_valid at T+3 with rsp_id=0, rsp_data=6'd8, rsp_err=0.
- Signed wrap: req1 sends a_op=0 with A=-16, B=-16.
  - Expect rsp_data=6'h20 (-32), rsp_id=1.
  - Then a_en=b_en=1, b_op=3, B=5 → expect rsp_data=6'd7.
- Round-robin: both requesters hold req_valid for 4 commands.
  - Expect the accept order 0,1,0,1.
  - Expect rsp_id to follow the same order, and no req_ready while busy=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - Expect rsp_valid and rsp_data held stable.
  - Expect no alu_en and req_ready=0 throughout.
  - Release rsp_ready → IDLE the next cycle.
- Reject: req0 sends a_en=b_en=0.
  - Expect rsp_err=1, rsp_data=0 at T+1 and zero alu_en pulses.
- Reset in WAIT with ALU_LAT=4: assert rst_n=0 mid-WAIT.
  - Expect all outputs 0 immediately.
  - After release with both requesters valid, expect requester 0 granted first.

Source files
------------

// File: rtl/alu_sched.sv
// Two-requester round-robin scheduler in front of one registered ALU.
// Latency: accept T, ALU pulse T+1, response valid T+2+ALU_LAT (T+1 for a rejected command).
// Backpressure: holds the response until rsp_ready; no new command is accepted until the response completes.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester command handshake (ready is one-hot or zero)
//   req0_cmd, req1_cmd         {a_en, b_en, a_op[2:0], b_op[1:0], A[4:0], B[4:0]}
//   alu_*                      ALU control/operand pins; alu_c is the ALU result input
//   rsp_valid/rsp_ready        response handshake carrying rsp_id, rsp_data, rsp_err
//   busy                       high whenever the scheduler is not idle
module alu_sched #(
   parameter int ALU_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [16:0] req0_cmd,
   input  logic [16:0] req1_cmd,
   output logic        alu_en,
   output logic        alu_a_en,
   output logic        alu_b_en,
   output logic [2:0]  alu_a_op,
   output logic [1:0]  alu_b_op,
   output logic [4:0]  alu_a,
   output logic [4:0]  alu_b,
   input  logic [5:0]  alu_c,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [5:0]  rsp_data,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

   state_t      state_q, state_d;
   logic        last_q;
   logic [16:0] cmd_q;
   logic        id_q;
   logic        err_q;
   logic [5:0]  data_q;
   logic [3:0]  cnt_q;

   logic        gnt;
   logic        accept;
   logic        rej;
   logic [16:0] cmd_sel;

   // A sole requester always wins; on a tie the one not granted last wins.
   always_comb begin
      gnt = ~last_q;
      if (req_valid == 2'b01) begin
         gnt = 1'b0;
      end else if (req_valid == 2'b10) begin
         gnt = 1'b1;
      end
   end

   assign accept  = (state_q == IDLE) && (req_valid != 2'b00);
   assign cmd_sel = gnt ? req1_cmd : req0_cmd;
   assign rej     = ~cmd_sel[16] & ~cmd_sel[15];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (accept) state_d = rej ? RESP : ISSUE;
         ISSUE: state_d = WAIT;
         WAIT:  if (cnt_q == 4'd0) state_d = RESP;
         RESP:  if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic; req_ready is forced low while reset is asserted
   always_comb begin
      alu_en    = (state_q == ISSUE);
      rsp_valid = (state_q == RESP);
      busy      = (state_q != IDLE);
      req_ready = 2'b00;
      if (rst_n && accept) begin
         req_ready = gnt ? 2'b10 : 2'b01;
      end
   end

   // Datapath. A rejected command leaves cmd_q alone so the ALU pins keep
   // the last issued values and the ALU never sees it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
         cmd_q  <= '0;
         id_q   <= 1'b0;
         err_q  <= 1'b0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (accept) begin
            last_q <= gnt;
            id_q   <= gnt;
            err_q  <= rej;
            if (rej) begin
               data_q <= '0;
            end else begin
               cmd_q <= cmd_sel;
            end
         end
         if (state_q == ISSUE) begin
            cnt_q <= CNT_INIT;
         end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (state_q == WAIT && cnt_q == 4'd0) begin
            data_q <= alu_c;
         end
      end
   end

   assign alu_a_en = cmd_q[16];
   assign alu_b_en = cmd_q[15];
   assign alu_a_op = cmd_q[14:12];
   assign alu_b_op = cmd_q[11:10];
   assign alu_a    = cmd_q[9:5];
   assign alu_b    = cmd_q[4:0];
   assign rsp_id   = id_q;
   assign rsp_data = data_q;
   assign rsp_err  = err_q;

endmodule
